// File: rtl/bus_hub_n.sv
// Registered host-to-N-device hub: decodes the host address against per-device
// base/mask windows, holds the selected device's strobe until it answers or times out.

module bus_hub_n_lane #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] mask,
    input  logic              active,
    input  logic              sel,
    input  logic              wr,
    output logic              match,
    output logic              ren,
    output logic              wen
);
    assign match = (addr & mask) == base;
    assign ren   = active & sel & ~wr;
    assign wen   = active & sel & wr;
endmodule

module bus_hub_n #(
    parameter int NUM_DEVICES = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter logic [NUM_DEVICES*ADDR_W-1:0] DEV_BASE = '0,
    parameter logic [NUM_DEVICES*ADDR_W-1:0] DEV_MASK = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_W-1:0]               host_address,
    input  logic [DATA_W-1:0]               host_data_write,
    input  logic [DATA_W/8-1:0]             host_write_mask,
    input  logic                            host_ren,
    input  logic                            host_wen,
    output logic [DATA_W-1:0]               host_data_read,
    output logic                            host_ready,
    output logic                            host_error,
    output logic [NUM_DEVICES*ADDR_W-1:0]   device_address,
    output logic [NUM_DEVICES*DATA_W-1:0]   device_data_write,
    output logic [NUM_DEVICES*DATA_W/8-1:0] device_write_mask,
    output logic [NUM_DEVICES-1:0]          device_ren,
    output logic [NUM_DEVICES-1:0]          device_wen,
    input  logic [NUM_DEVICES-1:0]          device_ready,
    input  logic [NUM_DEVICES*DATA_W-1:0]   device_data_read
);
    localparam int SEL_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] mask;
        logic                wr;
        logic [SEL_W-1:0]    sel;
    } req_t;

    state_t              state, state_d;
    req_t                req, req_d;
    logic [31:0]         cnt, cnt_d;
    logic [DATA_W-1:0]   resp_data, resp_data_d;
    logic                resp_err, resp_err_d;

    logic [NUM_DEVICES-1:0]             match;
    logic [NUM_DEVICES-1:0][DATA_W-1:0] rd_lane;
    logic                               hit;
    logic [SEL_W-1:0]                   hit_sel;

    for (genvar i = 0; i < NUM_DEVICES; i++) begin : g_lane
        bus_hub_n_lane #(.ADDR_W(ADDR_W)) u_lane (
            .addr   (host_address),
            .base   (DEV_BASE[i*ADDR_W +: ADDR_W]),
            .mask   (DEV_MASK[i*ADDR_W +: ADDR_W]),
            .active (state == ACCESS),
            .sel    (req.sel == SEL_W'(i)),
            .wr     (req.wr),
            .match  (match[i]),
            .ren    (device_ren[i]),
            .wen    (device_wen[i])
        );
        assign rd_lane[i] = device_data_read[i*DATA_W +: DATA_W];
    end

    // Scan high-to-low so the lowest matching index ends up selected.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state;
        req_d       = req;
        cnt_d       = cnt;
        resp_data_d = resp_data;
        resp_err_d  = resp_err;
        case (state)
            IDLE: begin
                if (host_ren || host_wen) begin
                    req_d.addr  = host_address;
                    req_d.wdata = host_data_write;
                    req_d.mask  = host_write_mask;
                    req_d.wr    = host_wen;
                    req_d.sel   = hit_sel;
                    if (hit) begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end else begin
                        state_d     = RESPOND;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked first so it beats a coincident timeout.
                if (device_ready[req.sel]) begin
                    state_d     = RESPOND;
                    resp_err_d  = 1'b0;
                    resp_data_d = req.wr ? '0 : rd_lane[req.sel];
                end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
                    state_d     = RESPOND;
                    resp_err_d  = 1'b1;
                    resp_data_d = '0;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            cnt       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state     <= state_d;
            req       <= req_d;
            cnt       <= cnt_d;
            resp_data <= resp_data_d;
            resp_err  <= resp_err_d;
        end
    end

    assign host_ready     = (state == RESPOND);
    assign host_error     = host_ready & resp_err;
    assign host_data_read = host_ready ? resp_data : '0;

    assign device_address    = {NUM_DEVICES{req.addr}};
    assign device_data_write = {NUM_DEVICES{req.wdata}};
    assign device_write_mask = {NUM_DEVICES{req.mask}};
endmodule

// File: tb/tb_bus_hub_n.sv
// Directed bench for bus_hub_n: decode, latency, hold-until-ready, unmapped,
// timeout, priority on overlapping windows and reset during an access.

module tb_bus_hub_n;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [N*AW-1:0] BASE = {32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [N*AW-1:0] MASK = {32'hFFFF_F000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     host_address = '0;
    logic [DW-1:0]     host_data_write = '0;
    logic [DW/8-1:0]   host_write_mask = '0;
    logic              host_ren = 1'b0;
    logic              host_wen = 1'b0;
    logic [DW-1:0]     host_data_read;
    logic              host_ready;
    logic              host_error;
    logic [N*AW-1:0]   device_address;
    logic [N*DW-1:0]   device_data_write;
    logic [N*DW/8-1:0] device_write_mask;
    logic [N-1:0]      device_ren;
    logic [N-1:0]      device_wen;
    logic [N-1:0]      device_ready;
    logic [N*DW-1:0]   device_data_read;

    int total = 0;
    int bad   = 0;

    // Device model: ready once a strobe has been held dly[i] cycles.
    int           dly [N];
    int           stb_cnt [N];
    logic [N-1:0] extra_ready = '0;

    always #5 clk = ~clk;

    bus_hub_n #(.NUM_DEVICES(N), .ADDR_W(AW), .DATA_W(DW), .DEV_BASE(BASE),
                .DEV_MASK(MASK), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .host_address(host_address),
        .host_data_write(host_data_write), .host_write_mask(host_write_mask),
        .host_ren(host_ren), .host_wen(host_wen), .host_data_read(host_data_read),
        .host_ready(host_ready), .host_error(host_error),
        .device_address(device_address), .device_data_write(device_data_write),
        .device_write_mask(device_write_mask), .device_ren(device_ren),
        .device_wen(device_wen), .device_ready(device_ready),
        .device_data_read(device_data_read)
    );

    assign device_data_read = {32'h3333_3333, 32'hCAFE_BABE, 32'h1111_1111, 32'hA0A0_A0A0};

    always @(posedge clk)
        for (int i = 0; i < N; i++)
            stb_cnt[i] <= (device_ren[i] | device_wen[i]) ? stb_cnt[i] + 1 : 0;

    always_comb
        for (int i = 0; i < N; i++)
            device_ready[i] = ((device_ren[i] | device_wen[i]) && stb_cnt[i] >= dly[i]) | extra_ready[i];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request sampled at edge 0, scramble the host inputs during the
    // access, then follow it cycle by cycle until host_ready.
    task automatic run_req(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [3:0] m, input logic r, input logic w,
                           input logic [N-1:0] exp_ren, input logic [N-1:0] exp_wen,
                           input int exp_stb, input int exp_lat,
                           input logic [DW-1:0] exp_data, input logic exp_err);
        int  stb;
        bit  done;
        stb  = 0;
        done = 0;
        @(negedge clk);
        host_address = a; host_data_write = wd; host_write_mask = m;
        host_ren = r; host_wen = w;
        @(posedge clk);
        #1;
        host_ren = 1'b0; host_wen = 1'b0;
        host_address = 32'hDEAD_BEEF; host_data_write = 32'h5555_AAAA; host_write_mask = 4'hF;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (host_ready) begin
                chk({tag, "_lat"}, 128'(cyc), 128'(exp_lat));
                chk({tag, "_data"}, 128'(host_data_read), 128'(exp_data));
                chk({tag, "_err"}, 128'(host_error), 128'(exp_err));
                chk({tag, "_strobes"}, 128'(device_ren | device_wen), 128'(0));
                chk({tag, "_stbcount"}, 128'(stb), 128'(exp_stb));
                done = 1;
            end else if ((device_ren | device_wen) != 0) begin
                stb++;
                if (stb == 1 || stb == exp_stb) begin
                    chk({tag, "_ren"}, 128'(device_ren), 128'(exp_ren));
                    chk({tag, "_wen"}, 128'(device_wen), 128'(exp_wen));
                    chk({tag, "_bcast_addr"}, 128'(device_address), 128'({N{a}}));
                    chk({tag, "_idle_data"}, 128'(host_data_read), 128'(0));
                end
            end
        end
        if (!done) chk({tag, "_no_ready"}, 128'(0), 128'(1));
        @(negedge clk);
        chk({tag, "_single_pulse"}, 128'(host_ready), 128'(0));
    endtask

    initial begin
        for (int i = 0; i < N; i++) dly[i] = 0;
        #12;
        chk("rst_ready", 128'(host_ready), 128'(0));
        chk("rst_err", 128'(host_error), 128'(0));
        chk("rst_data", 128'(host_data_read), 128'(0));
        chk("rst_strobes", 128'({device_ren, device_wen}), 128'(0));
        chk("rst_addr", 128'(device_address), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        run_req("rd_dev2", 32'h2000_0010, 32'h0, 4'h0, 1'b1, 1'b0,
                4'b0100, 4'b0000, 1, 2, 32'hCAFE_BABE, 1'b0);

        // Write with ren also set; a stray ready on device 2 must be ignored.
        dly[1] = 5;
        extra_ready = 4'b0100;
        fork
            run_req("wr_dev1", 32'h1000_0004, 32'h1234_5678, 4'b0011, 1'b1, 1'b1,
                    4'b0000, 4'b0010, 6, 7, 32'h0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                chk("wr_bcast_data", 128'(device_data_write), 128'({N{32'h1234_5678}}));
                chk("wr_bcast_mask", 128'(device_write_mask), 128'({N{4'b0011}}));
            end
        join
        extra_ready = '0;
        dly[1] = 0;

        run_req("unmapped", 32'hF000_0000, 32'h0, 4'h0, 1'b1, 1'b0,
                4'b0000, 4'b0000, 0, 1, 32'h0, 1'b1);

        dly[2] = 1000;
        run_req("timeout", 32'h2000_0020, 32'h0, 4'h0, 1'b1, 1'b0,
                4'b0100, 4'b0000, 8, 9, 32'h0, 1'b1);

        run_req("overlap", 32'h0000_0100, 32'h0, 4'h0, 1'b1, 1'b0,
                4'b0001, 4'b0000, 1, 2, 32'hA0A0_A0A0, 1'b0);

        // Reset in the third ACCESS cycle of a stalled read.
        @(negedge clk);
        host_address = 32'h2000_0040; host_ren = 1'b1;
        @(posedge clk);
        #1;
        host_ren = 1'b0;
        @(negedge clk);
        chk("pre_rst_stb", 128'(device_ren), 128'(4'b0100));
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_stb", 128'({device_ren, device_wen}), 128'(0));
        chk("rst_mid_ready", 128'(host_ready), 128'(0));
        @(negedge clk);
        chk("rst_hold_ready", 128'(host_ready), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 128'(host_ready), 128'(0));
        dly[2] = 0;
        run_req("rd_after_rst", 32'h2000_0010, 32'h0, 4'h0, 1'b1, 1'b0,
                4'b0100, 4'b0000, 1, 2, 32'hCAFE_BABE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
